// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain stage: integrates (target - level) into a clamped gain
// register and applies that gain to the sample stream with rounding and saturation.
module agc_gain_ctrl #(
    parameter int DWIDTH    = 27,
    parameter int LWIDTH    = 48,
    parameter int GWIDTH    = 18,
    parameter int GAIN_INIT = 4096,
    parameter int GAIN_MIN  = 1,
    parameter int GAIN_MAX  = 262143,
    parameter int WARMUP    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [LWIDTH-1:0] Level_In,
    input  logic                     Level_Valid,
    input  logic        [DWIDTH-1:0] Target_Level,
    input  logic        [4:0]        Step_Shift,
    input  logic                     Freeze,
    input  logic signed [DWIDTH-1:0] Sample_In,
    input  logic                     Sample_Valid,
    output logic signed [DWIDTH-1:0] Sample_Out,
    output logic                     Valid_Out,
    output logic        [GWIDTH-1:0] Gain_Out,
    output logic                     Gain_Clamped
);

    localparam int LVL_SHIFT = 14;           // Q(.,32) level -> Q(.,18)
    localparam int ERR_SHIFT = 6;            // Q(.,18) error -> Q(.,12) gain step
    localparam int GFRAC     = 12;
    localparam int EWIDTH    = DWIDTH + 1;
    localparam int SWIDTH    = EWIDTH + 2;
    localparam int PWIDTH    = DWIDTH + GWIDTH;
    localparam int CWIDTH    = $clog2(WARMUP + 1);

    localparam logic signed [SWIDTH-1:0] SUM_MAX   = SWIDTH'(GAIN_MAX);
    localparam logic signed [SWIDTH-1:0] SUM_MIN   = SWIDTH'(GAIN_MIN);
    localparam logic signed [PWIDTH:0]   OUT_MAX   = (PWIDTH+1)'(2**(DWIDTH-1) - 1);
    localparam logic signed [PWIDTH:0]   OUT_MIN   = (PWIDTH+1)'(-(2**(DWIDTH-1)));
    localparam logic signed [PWIDTH:0]   RND_HALF  = (PWIDTH+1)'(2**(GFRAC-1));

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t                    state;
    logic [CWIDTH-1:0]         warm_cnt;

    logic signed [LWIDTH-1:0]  lvl_shift;
    logic        [DWIDTH-1:0]  lvl_sat;
    logic        [DWIDTH-1:0]  lvl_q;
    logic signed [EWIDTH-1:0]  err_q;
    logic signed [EWIDTH-1:0]  delta;
    logic signed [SWIDTH-1:0]  sum;
    logic        [GWIDTH-1:0]  gain_next;
    logic                      clamp_next;
    logic                      lvl_v1;
    logic                      lvl_v2;

    logic signed [DWIDTH-1:0]  s1_sample;
    logic        [GWIDTH-1:0]  s1_gain;
    logic signed [PWIDTH-1:0]  s2_prod;
    logic signed [PWIDTH:0]    rnd_sum;
    logic signed [PWIDTH:0]    rnd_shift;
    logic signed [DWIDTH-1:0]  out_sat;
    logic                      smp_v1;
    logic                      smp_v2;

    // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
    always_comb begin
        lvl_shift = Level_In >>> LVL_SHIFT;
        lvl_sat   = lvl_shift[DWIDTH-1:0];
        if (lvl_shift[LWIDTH-1]) begin
            lvl_sat = '0;
        end else if (|lvl_shift[LWIDTH-2:DWIDTH]) begin
            lvl_sat = '1;
        end
    end

    always_comb begin
        delta      = err_q >>> (ERR_SHIFT + Step_Shift);
        sum        = $signed({{(SWIDTH-GWIDTH){1'b0}}, Gain_Out}) + SWIDTH'(delta);
        gain_next  = sum[GWIDTH-1:0];
        clamp_next = 1'b0;
        if (sum > SUM_MAX) begin
            gain_next  = GWIDTH'(GAIN_MAX);
            clamp_next = 1'b1;
        end else if (sum < SUM_MIN) begin
            gain_next  = GWIDTH'(GAIN_MIN);
            clamp_next = 1'b1;
        end
    end

    always_comb begin
        rnd_sum   = (PWIDTH+1)'(s2_prod) + RND_HALF;
        rnd_shift = rnd_sum >>> GFRAC;
        out_sat   = rnd_shift[DWIDTH-1:0];
        if (rnd_shift > OUT_MAX) begin
            out_sat = OUT_MAX[DWIDTH-1:0];
        end else if (rnd_shift < OUT_MIN) begin
            out_sat = OUT_MIN[DWIDTH-1:0];
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone flush the pipeline.
    always_ff @(posedge clk) begin
        if (Level_Valid) begin
            lvl_q <= lvl_sat;
        end
        if (lvl_v1) begin
            err_q <= $signed({1'b0, Target_Level}) - $signed({1'b0, lvl_q});
        end
        if (Sample_Valid) begin
            s1_sample <= Sample_In;
            s1_gain   <= Gain_Out;
        end
        if (smp_v1) begin
            s2_prod <= PWIDTH'(s1_sample) * PWIDTH'($signed({1'b0, s1_gain}));
        end
    end

    // Freeze kills level updates already in L1/L2 so none survive a HOLD period.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_v1     <= 1'b0;
            lvl_v2     <= 1'b0;
            smp_v1     <= 1'b0;
            smp_v2     <= 1'b0;
            Valid_Out  <= 1'b0;
            Sample_Out <= '0;
        end else begin
            lvl_v1    <= Level_Valid & ~Freeze;
            lvl_v2    <= lvl_v1 & ~Freeze;
            smp_v1    <= Sample_Valid;
            smp_v2    <= smp_v1;
            Valid_Out <= smp_v2;
            if (smp_v2) begin
                Sample_Out <= out_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            warm_cnt     <= '0;
            Gain_Out     <= GWIDTH'(GAIN_INIT);
            Gain_Clamped <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lvl_v2) begin
                        warm_cnt <= warm_cnt + 1'b1;
                        if (warm_cnt == CWIDTH'(WARMUP - 1)) begin
                            state <= Freeze ? HOLD : TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (lvl_v2) begin
                        Gain_Out     <= gain_next;
                        Gain_Clamped <= clamp_next;
                    end
                    if (Freeze) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!Freeze) begin
                        state <= TRACK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
